endec_frame_packer: RTL and testbench

- Sits between the convolutional encoder output and the Viterbi decoder frame input.
- Collects per-cycle code symbols (2 or 3 bits, depending on code rate) into a 384-bit frame and presents it to the decoder with a valid/ready handshake.
- Double-buffered: one fill buffer plus one output register, so the encoder keeps streaming while a frame waits.
- Used for loopback verification and as the transmit-side framer feeding the decoder.

---
 rtl/endec_frame_packer.sv | 183 ++++++++++++++++++
 tb/tb_endec_frame_packer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/endec_frame_packer.sv
// endec_frame_packer
//
// Purpose:
//   Collects per-cycle convolutional code symbols (2 bits at rate 1/2, 3 bits
//   at rate 1/3) into a FRAME_BITS-wide frame and hands it to the Viterbi
//   decoder over a valid/ready handshake. A fill buffer plus an output
//   register let the encoder keep streaming while a finished frame waits.
//
// Ports:
//   sys_clk        clock, rising edge
//   rst            asynchronous active-high reset
//   en             block enable; when low the fill side holds and o_sym_ready=0
//   i_code_rate    0 = rate 1/2, 1 = rate 1/3 (sampled on a frame's first symbol)
//   i_sym          code symbol, bit 0 = first generator output
//   i_sym_valid    symbol valid
//   o_sym_ready    packer can accept a symbol
//   i_flush        single-cycle pulse that closes a partial frame
//   o_frame        packed frame, symbol k at [k*W +: W]
//   o_frame_valid  o_frame holds an unconsumed frame
//   i_frame_ready  decoder accepts the frame
//   o_frame_len    number of symbols in o_frame
//   o_frame_rate   code rate latched for o_frame
//   i_err_inj      (ERR_INJECT_EN only) enables periodic bit-0 inversion
//
// Optional feature macro: ERR_INJECT_EN

module endec_frame_packer #(
    parameter int FRAME_BITS    = 384,
    parameter int MAX_CODE_RATE = 3,
    parameter int ERR_PERIOD    = 17
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     i_code_rate,
    input  logic [MAX_CODE_RATE-1:0] i_sym,
    input  logic                     i_sym_valid,
    output logic                     o_sym_ready,
    input  logic                     i_flush,
    output logic [FRAME_BITS-1:0]    o_frame,
    output logic                     o_frame_valid,
    input  logic                     i_frame_ready,
    output logic [7:0]               o_frame_len,
    output logic                     o_frame_rate
`ifdef ERR_INJECT_EN
    ,
    input  logic                     i_err_inj
`endif
);

    // Index of the last symbol of a full frame for each rate.
    localparam logic [7:0] LAST_R2 = 8'(FRAME_BITS / 2 - 1);
    localparam logic [7:0] LAST_R3 = 8'(FRAME_BITS / 3 - 1);

    // Elaboration-time sanity checks on the configuration.
    if ((FRAME_BITS % 6) != 0 || FRAME_BITS / 2 > 255) begin : g_bad_frame_bits
        $error("endec_frame_packer: FRAME_BITS must be divisible by 6 and at most 510");
    end
    if (ERR_PERIOD < 1 || ERR_PERIOD > 256) begin : g_bad_err_period
        $error("endec_frame_packer: ERR_PERIOD must be in 1..256");
    end

    typedef enum logic {
        FILL,
        FULL
    } state_e;

    state_e                state_q;
    logic [FRAME_BITS-1:0] fill_q;
    logic [FRAME_BITS-1:0] fill_d;
    logic [7:0]            count_q;
    logic [7:0]            len_d;
    logic                  rate_q;
    logic                  rate_cur;
    logic                  accept;
    logic                  consume;
    logic                  slot_free;
    logic                  last_sym;
    logic                  close;
    logic [2:0]            sym_eff;

    // Ready is gated by rst so nothing is offered while reset is asserted.
    assign o_sym_ready = en && !rst && (state_q == FILL);
    assign accept      = i_sym_valid && o_sym_ready;
    assign consume     = o_frame_valid && i_frame_ready;
    assign slot_free   = !o_frame_valid || i_frame_ready;

    // The rate is taken live on a frame's first symbol, then held.
    assign rate_cur = (count_q == 8'd0) ? i_code_rate : rate_q;
    assign last_sym = accept && (count_q == (rate_cur ? LAST_R3 : LAST_R2));
    assign close    = (state_q == FILL) &&
                      (last_sym || (en && i_flush && (accept || count_q != 8'd0)));
    assign len_d    = count_q + {7'd0, accept};

`ifdef ERR_INJECT_EN
    localparam logic [7:0] ERR_LAST = 8'(ERR_PERIOD - 1);

    logic [7:0] err_cnt_q;

    assign sym_eff = {i_sym[2:1], i_sym[0] ^ (i_err_inj && (err_cnt_q == ERR_LAST))};

    // Free-running count of accepted symbols; deliberately not cleared at
    // frame boundaries so the error pattern spans frames.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (accept) begin
            err_cnt_q <= (err_cnt_q == ERR_LAST) ? 8'd0 : err_cnt_q + 8'd1;
        end
    end
`else
    assign sym_eff = i_sym[2:0];
`endif

    // Fill buffer with the current symbol merged in; bit 2 is dropped at rate 1/2.
    always_comb begin
        fill_d = fill_q;
        if (accept) begin
            if (rate_cur) begin
                fill_d[int'(count_q) * 3 +: 3] = sym_eff;
            end else begin
                fill_d[int'(count_q) * 2 +: 2] = sym_eff[1:0];
            end
        end
    end

    // Packer FSM. In FULL the fill buffer itself holds the closed frame
    // (count_q/rate_q describe it) until the output register frees up.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q       <= FILL;
            count_q       <= '0;
            rate_q        <= 1'b0;
            fill_q        <= '0;
            o_frame       <= '0;
            o_frame_valid <= 1'b0;
            o_frame_len   <= '0;
            o_frame_rate  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (close) begin
                        if (slot_free) begin
                            o_frame       <= fill_d;
                            o_frame_len   <= len_d;
                            o_frame_rate  <= rate_cur;
                            o_frame_valid <= 1'b1;
                            fill_q        <= '0;
                            count_q       <= '0;
                        end else begin
                            state_q <= FULL;
                            fill_q  <= fill_d;
                            count_q <= len_d;
                            rate_q  <= rate_cur;
                        end
                    end else begin
                        if (consume) begin
                            o_frame_valid <= 1'b0;
                        end
                        if (accept) begin
                            fill_q  <= fill_d;
                            count_q <= len_d;
                            rate_q  <= rate_cur;
                        end
                    end
                end
                FULL: begin
                    // Back-to-back transfer: o_frame_valid stays high.
                    if (consume) begin
                        o_frame      <= fill_q;
                        o_frame_len  <= count_q;
                        o_frame_rate <= rate_q;
                        fill_q       <= '0;
                        count_q      <= '0;
                        state_q      <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_endec_frame_packer.sv
// tb_endec_frame_packer
//
// Directed bench for endec_frame_packer: a table of whole-frame vectors
// (rate, symbol, count, flush, expected frame/len) plus hand-written
// sequences for backpressure, enable gating, empty flush and async reset.

module tb_endec_frame_packer;

    localparam int FB = 384;

    logic          sys_clk;
    logic          rst;
    logic          en;
    logic          i_code_rate;
    logic [2:0]    i_sym;
    logic          i_sym_valid;
    logic          o_sym_ready;
    logic          i_flush;
    logic [FB-1:0] o_frame;
    logic          o_frame_valid;
    logic          i_frame_ready;
    logic [7:0]    o_frame_len;
    logic          o_frame_rate;
`ifdef ERR_INJECT_EN
    logic          i_err_inj;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic          rate;
        logic [2:0]    sym;
        int            nsyms;
        logic          flush;
        logic [FB-1:0] frame;
        logic [7:0]    len;
    } vec_t;

    vec_t vecs[5];

    endec_frame_packer #(
        .FRAME_BITS   (FB),
        .MAX_CODE_RATE(3),
        .ERR_PERIOD   (17)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .en           (en),
        .i_code_rate  (i_code_rate),
        .i_sym        (i_sym),
        .i_sym_valid  (i_sym_valid),
        .o_sym_ready  (o_sym_ready),
        .i_flush      (i_flush),
        .o_frame      (o_frame),
        .o_frame_valid(o_frame_valid),
        .i_frame_ready(i_frame_ready),
        .o_frame_len  (o_frame_len),
        .o_frame_rate (o_frame_rate)
`ifdef ERR_INJECT_EN
        ,
        .i_err_inj    (i_err_inj)
`endif
    );

    // 100 MHz clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Hard stop in case a sequence ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Drive one cycle of inputs and step past the next rising edge.
    task automatic applyStimulus(input logic v, input logic [2:0] s, input logic r,
                                 input logic f, input logic fr);
        i_sym_valid   = v;
        i_sym         = s;
        i_code_rate   = r;
        i_flush       = f;
        i_frame_ready = fr;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [FB-1:0] act,
                               input logic [FB-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, FB'(act), FB'(exp));
    endtask

    task automatic checkLen(input string name, input logic [7:0] act, input logic [7:0] exp);
        checkOutput(name, FB'(act), FB'(exp));
    endtask

    // Send n identical symbols at the given rate, frame not consumed.
    task automatic sendSymbols(input logic r, input logic [2:0] s, input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, s, r, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [FB-1:0] expFrame;

        vecs[0] = '{1'b0, 3'b001, 192, 1'b0, {192{2'b01}}, 8'd192};
        vecs[1] = '{1'b1, 3'b110, 128, 1'b0, {128{3'b110}}, 8'd128};
        vecs[2] = '{1'b0, 3'b011, 10, 1'b1, FB'(20'hFFFFF), 8'd10};
        vecs[3] = '{1'b1, 3'b101, 5, 1'b1, FB'(15'b101101101101101), 8'd5};
        vecs[4] = '{1'b0, 3'b110, 7, 1'b1, FB'(14'h2AAA), 8'd7};

        rst           = 1'b1;
        en            = 1'b1;
        i_code_rate   = 1'b0;
        i_sym         = 3'b000;
        i_sym_valid   = 1'b0;
        i_flush       = 1'b0;
        i_frame_ready = 1'b0;
`ifdef ERR_INJECT_EN
        i_err_inj     = 1'b0;
`endif

        // Reset state, sampled with rst still high.
        #12;
        checkBit("reset_sym_ready", o_sym_ready, 1'b0);
        checkBit("reset_frame_valid", o_frame_valid, 1'b0);
        checkOutput("reset_frame", o_frame, '0);
        checkLen("reset_frame_len", o_frame_len, 8'd0);
        checkBit("reset_frame_rate", o_frame_rate, 1'b0);
        @(negedge sys_clk);
        rst = 1'b0;
        #1;
        checkBit("post_reset_sym_ready", o_sym_ready, 1'b1);

`ifdef ERR_INJECT_EN
        // Error injection: every 17th accepted symbol gets bit 0 inverted.
        i_err_inj = 1'b1;
        sendSymbols(1'b0, 3'b000, 192);
        i_err_inj = 1'b0;
        expFrame = '0;
        for (int j = 16; j < 192; j += 17) begin
            expFrame[2 * j] = 1'b1;
        end
        checkBit("err_valid", o_frame_valid, 1'b1);
        checkOutput("err_frame", o_frame, expFrame);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
`endif

        // Table of full and flushed frames; the rate input is flipped after the
        // first symbol to show it is latched only at the frame start.
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < vecs[i].nsyms; k++) begin
                applyStimulus(1'b1, vecs[i].sym, (k >= 1) ? ~vecs[i].rate : vecs[i].rate,
                              1'b0, 1'b0);
                if (k == vecs[i].nsyms - 2) begin
                    checkBit($sformatf("vec%0d_not_early", i), o_frame_valid, 1'b0);
                end
            end
            if (vecs[i].flush) begin
                applyStimulus(1'b0, 3'b000, ~vecs[i].rate, 1'b1, 1'b0);
            end
            checkBit($sformatf("vec%0d_valid", i), o_frame_valid, 1'b1);
            checkOutput($sformatf("vec%0d_frame", i), o_frame, vecs[i].frame);
            checkLen($sformatf("vec%0d_len", i), o_frame_len, vecs[i].len);
            checkBit($sformatf("vec%0d_rate", i), o_frame_rate, vecs[i].rate);
            applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
            checkBit($sformatf("vec%0d_consumed", i), o_frame_valid, 1'b0);
        end

        // Flush with an empty fill buffer produces nothing.
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        checkBit("empty_flush_no_frame", o_frame_valid, 1'b0);

        // Backpressure: two frames with the decoder stalled.
        sendSymbols(1'b0, 3'b001, 192);
        checkBit("bp_a_valid", o_frame_valid, 1'b1);
        checkBit("bp_ready_after_a", o_sym_ready, 1'b1);
        sendSymbols(1'b0, 3'b010, 192);
        checkBit("bp_ready_after_b", o_sym_ready, 1'b0);
        checkOutput("bp_a_held", o_frame, {192{2'b01}});
        applyStimulus(1'b1, 3'b011, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'b011, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_a_still_held", o_frame, {192{2'b01}});
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        checkBit("bp_b_back_to_back", o_frame_valid, 1'b1);
        checkOutput("bp_b_frame", o_frame, {192{2'b10}});
        checkLen("bp_b_len", o_frame_len, 8'd192);
        checkBit("bp_ready_restored", o_sym_ready, 1'b1);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        checkBit("bp_b_consumed", o_frame_valid, 1'b0);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        checkBit("bp_nothing_leaked", o_frame_valid, 1'b0);

        // Enable low mid-frame: symbols and flush ignored, state held.
        sendSymbols(1'b1, 3'b011, 5);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 3'b111, 1'b0, 1'b1, 1'b0);
        end
        checkBit("en_low_sym_ready", o_sym_ready, 1'b0);
        checkBit("en_low_no_frame", o_frame_valid, 1'b0);
        en = 1'b1;
        sendSymbols(1'b0, 3'b011, 3);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        checkOutput("en_frame", o_frame, FB'(24'h6DB6DB));
        checkLen("en_len", o_frame_len, 8'd8);
        checkBit("en_rate", o_frame_rate, 1'b1);
        en = 1'b0;
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        checkBit("en_low_consume", o_frame_valid, 1'b0);
        en = 1'b1;

        // Async reset with a frame pending and another half filled.
        sendSymbols(1'b0, 3'b011, 4);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        checkBit("rst_pending_valid", o_frame_valid, 1'b1);
        sendSymbols(1'b0, 3'b001, 100);
        #1;
        rst = 1'b1;
        #1;
        checkBit("rst_async_valid", o_frame_valid, 1'b0);
        checkOutput("rst_async_frame", o_frame, '0);
        checkBit("rst_async_sym_ready", o_sym_ready, 1'b0);
        @(negedge sys_clk);
        rst = 1'b0;
        #1;
        sendSymbols(1'b0, 3'b001, 3);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        checkOutput("rst_restart_frame", o_frame, FB'(6'h15));
        checkLen("rst_restart_len", o_frame_len, 8'd3);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
